// File: rtl/fp_add_pipe_pkg.sv
// Shared types and format constants for the pipelined floating-point adder.
package fp_add_pipe_pkg;

  localparam int unsigned C_EXP_FP16  = 5;
  localparam int unsigned C_MANT_FP16 = 10;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
  } fp_flags_t;

  // Result class decided in the align stage and carried down the pipe
  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } fp_special_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 14
) (
  input  logic [WIDTH-1:0]               data,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit makes the final assignment
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data[i]) count = CW'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage FP adder/subtractor (align, add, normalise/round) with a globally stalled
// valid/ready pipe; denormals flush to zero, rounding is nearest-even.
module fp_add_pipe
  import fp_add_pipe_pkg::*;
#(
  parameter int unsigned C_EXP  = C_EXP_FP16,
  parameter int unsigned C_MANT = C_MANT_FP16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [C_EXP+C_MANT:0]     a_i,
  input  logic [C_EXP+C_MANT:0]     b_i,
  input  logic                      sub_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [C_EXP+C_MANT:0]     result_o,
  output logic                      overflow_o,
  output logic                      underflow_o,
  output logic                      invalid_o
);

  localparam int unsigned W  = C_EXP + C_MANT + 1;
  localparam int unsigned SW = C_MANT + 1;   // significand with hidden bit
  localparam int unsigned AW = C_MANT + 3;   // aligned small operand {sig, G, R}
  localparam int unsigned NW = C_MANT + 5;   // {carry, sig, G, R, S}
  localparam int unsigned EW = C_EXP + 2;    // signed exponent during normalisation
  localparam int unsigned LW = $clog2(NW);
  localparam int unsigned RW = C_MANT + 2;

  localparam logic [C_EXP-1:0] EXP_MAX   = '1;
  localparam logic [W-1:0]     CANON_NAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

  typedef struct packed {
    logic              valid;
    fp_special_e       special;
    logic              spec_sign;
    logic              sign;
    logic              eff_sub;
    logic [C_EXP-1:0]  exp;
    logic [SW-1:0]     big_sig;
    logic [AW-1:0]     small_sig;
    logic              sticky;
  } s1_t;

  typedef struct packed {
    logic              valid;
    fp_special_e       special;
    logic              spec_sign;
    logic              sign;
    logic [C_EXP-1:0]  exp;
    logic [NW-1:0]     sum;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic adv;
  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv;

  // Operand decode; B sign is pre-inverted for subtraction
  logic              sa, sb;
  logic [C_EXP-1:0]  ea, eb;
  logic [C_MANT-1:0] ma, mb;
  assign sa = a_i[W-1];
  assign ea = a_i[W-2:C_MANT];
  assign ma = a_i[C_MANT-1:0];
  assign sb = b_i[W-1] ^ sub_i;
  assign eb = b_i[W-2:C_MANT];
  assign mb = b_i[C_MANT-1:0];

  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic              small_zero;
  logic [C_EXP-1:0]  small_exp, shift_d;
  logic [C_MANT-1:0] small_mant;
  logic [AW-1:0]     small_full;

  // Stage 1: classify, swap, align the smaller operand
  always_comb begin
    s1_d       = '0;
    a_zero     = (ea == '0);
    b_zero     = (eb == '0);
    a_inf      = (ea == EXP_MAX) && (ma == '0);
    b_inf      = (eb == EXP_MAX) && (mb == '0);
    a_nan      = (ea == EXP_MAX) && (ma != '0);
    b_nan      = (eb == EXP_MAX) && (mb != '0);
    a_big      = ({ea, ma} >= {eb, mb});

    s1_d.valid   = in_valid_i;
    s1_d.eff_sub = sa ^ sb;
    s1_d.sign    = a_big ? sa : sb;
    s1_d.exp     = a_big ? ea : eb;
    s1_d.big_sig = {1'b1, (a_big ? ma : mb)};
    small_exp    = a_big ? eb : ea;
    small_mant   = a_big ? mb : ma;
    small_zero   = a_big ? b_zero : a_zero;
    small_full   = small_zero ? '0 : {1'b1, small_mant, 2'b00};
    shift_d      = s1_d.exp - small_exp;

    if (32'(shift_d) >= AW) begin
      s1_d.small_sig = '0;
      s1_d.sticky    = |small_full;
    end else begin
      s1_d.small_sig = small_full >> shift_d;
      s1_d.sticky    = |(small_full & ~({AW{1'b1}} << shift_d));
    end

    s1_d.special   = SP_NONE;
    s1_d.spec_sign = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_d.special = SP_NAN;
    end else if (a_inf) begin
      s1_d.special   = SP_INF;
      s1_d.spec_sign = sa;
    end else if (b_inf) begin
      s1_d.special   = SP_INF;
      s1_d.spec_sign = sb;
    end else if (a_zero && b_zero) begin
      s1_d.special   = SP_ZERO;
      s1_d.spec_sign = sa & sb;
    end
  end

  logic [NW-1:0] big_ext, small_ext;

  // Stage 2: magnitude add/subtract; exact cancellation gives +0
  always_comb begin
    s2_d           = '0;
    big_ext        = {1'b0, s1_q.big_sig, 3'b000};
    small_ext      = {1'b0, s1_q.small_sig, s1_q.sticky};
    s2_d.valid     = s1_q.valid;
    s2_d.special   = s1_q.special;
    s2_d.spec_sign = s1_q.spec_sign;
    s2_d.sign      = s1_q.sign;
    s2_d.exp       = s1_q.exp;
    s2_d.sum       = s1_q.eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);
    if ((s1_q.special == SP_NONE) && (s2_d.sum == '0)) begin
      s2_d.special   = SP_ZERO;
      s2_d.spec_sign = 1'b0;
    end
  end

  logic [LW-1:0] lzc;

  fp_lzc #(
    .WIDTH (NW - 1)
  ) u_lzc (
    .data  (s2_q.sum[NW-2:0]),
    .count (lzc)
  );

  logic [NW-2:0]     norm;
  logic [EW-1:0]     exp_n, exp_r;
  logic [RW-1:0]     rounded;
  logic              round_up, uf, of;
  logic [C_MANT-1:0] mant_f;
  logic [W-1:0]      result_d;
  fp_flags_t         flags_d;

  // Stage 3: normalise, round to nearest even, range check, apply specials
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (s2_q.sum[NW-1]) begin
      norm  = {s2_q.sum[NW-1:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n = EW'(s2_q.exp) + EW'(1);
    end else begin
      norm  = s2_q.sum[NW-2:0] << lzc;
      exp_n = EW'(s2_q.exp) - EW'(lzc);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[NW-2:3]} + RW'(round_up);
    if (rounded[RW-1]) begin
      mant_f = rounded[C_MANT:1];
      exp_r  = exp_n + EW'(1);
    end else begin
      mant_f = rounded[C_MANT-1:0];
      exp_r  = exp_n;
    end
    uf = exp_n[EW-1] || (exp_n == '0);
    of = !exp_r[EW-1] && (exp_r >= EW'(EXP_MAX));

    case (s2_q.special)
      SP_NAN: begin
        result_d        = CANON_NAN;
        flags_d.invalid = 1'b1;
      end
      SP_INF:  result_d = {s2_q.spec_sign, EXP_MAX, {C_MANT{1'b0}}};
      SP_ZERO: result_d = {s2_q.spec_sign, {(W-1){1'b0}}};
      default: begin
        if (uf) begin
          result_d          = {s2_q.sign, {(W-1){1'b0}}};
          flags_d.underflow = 1'b1;
        end else if (of) begin
          result_d         = {s2_q.sign, EXP_MAX, {C_MANT{1'b0}}};
          flags_d.overflow = 1'b1;
        end else begin
          result_d = {s2_q.sign, exp_r[C_EXP-1:0], mant_f};
        end
      end
    endcase
  end

  // Whole pipe advances together; bubbles travel with their valid bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else if (adv) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_o <= s2_q.valid;
      result_o    <= result_d;
      overflow_o  <= flags_d.overflow;
      underflow_o <= flags_d.underflow;
      invalid_o   <= flags_d.invalid;
    end
  end

endmodule
